// File: rtl/mod_n_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mod_n_counter_ctrl
// Brief    : Configurable mod-N counter controller. Takes a valid/ready config,
//            then counts with start/pause/abort in continuous or one-shot mode.
// Revision : 1.0 - initial release
// ============================================================================
module mod_n_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mod,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             cfg_oneshot,
    output logic             cfg_err,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_MOD_RESET = '1;
    localparam logic [WIDTH-1:0] C_MOD_MIN   = WIDTH'(2);
    localparam logic [WIDTH-1:0] C_CNT_ONE   = WIDTH'(1);
    localparam logic [REP_W-1:0] C_REP_ONE   = REP_W'(1);

    state_t           r_state_q,   w_state_d;
    logic [WIDTH-1:0] r_count_q,   w_count_d;
    logic [WIDTH-1:0] r_mod_q,     w_mod_d;
    logic [REP_W-1:0] r_reps_q,    w_reps_d;
    logic             r_oneshot_q, w_oneshot_d;
    logic [REP_W-1:0] r_rep_cnt_q, w_rep_cnt_d;
    logic             r_cfg_err_q, w_cfg_err_d;
    logic             r_done_q,    w_done_d;

    logic             w_cfg_xfer;
    logic             w_cfg_ok;
    logic             w_last_count;
    logic             w_last_rep;

    assign cfg_ready    = (r_state_q == ST_IDLE) || (r_state_q == ST_DONE);
    assign w_cfg_xfer   = cfg_valid && cfg_ready;
    assign w_cfg_ok     = cfg_mod >= C_MOD_MIN;
    // mod_r is always >= 2, so mod_r-1 never underflows
    assign w_last_count = r_count_q == (r_mod_q - C_CNT_ONE);
    assign w_last_rep   = r_rep_cnt_q == (r_reps_q - C_REP_ONE);

    always_comb begin
        w_state_d   = r_state_q;
        w_count_d   = r_count_q;
        w_mod_d     = r_mod_q;
        w_reps_d    = r_reps_q;
        w_oneshot_d = r_oneshot_q;
        w_rep_cnt_d = r_rep_cnt_q;
        w_cfg_err_d = 1'b0;
        w_done_d    = 1'b0;

        if (w_cfg_xfer) begin
            if (w_cfg_ok) begin
                w_mod_d     = cfg_mod;
                w_reps_d    = (cfg_reps == '0) ? C_REP_ONE : cfg_reps;
                w_oneshot_d = cfg_oneshot;
            end else begin
                w_cfg_err_d = 1'b1;
            end
        end

        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_d   = ST_RUN;
                    w_count_d   = '0;
                    w_rep_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_d   = ST_IDLE;
                    w_count_d   = '0;
                    w_rep_cnt_d = '0;
                end else if (pause) begin
                    w_state_d   = ST_PAUSE;
                end else if (w_last_count) begin
                    w_count_d   = '0;
                    w_rep_cnt_d = r_rep_cnt_q + C_REP_ONE;
                    if (r_oneshot_q && w_last_rep) begin
                        w_state_d   = ST_DONE;
                        w_rep_cnt_d = '0;
                        w_done_d    = 1'b1;
                    end
                end else begin
                    w_count_d   = r_count_q + C_CNT_ONE;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    w_state_d   = ST_IDLE;
                    w_count_d   = '0;
                    w_rep_cnt_d = '0;
                end else if (!pause) begin
                    w_state_d   = ST_RUN;
                end
            end
            default: begin
                w_state_d   = ST_IDLE;
                w_count_d   = '0;
                w_rep_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q   <= ST_IDLE;
            r_count_q   <= '0;
            r_mod_q     <= C_MOD_RESET;
            r_reps_q    <= C_REP_ONE;
            r_oneshot_q <= 1'b0;
            r_rep_cnt_q <= '0;
            r_cfg_err_q <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_count_q   <= w_count_d;
            r_mod_q     <= w_mod_d;
            r_reps_q    <= w_reps_d;
            r_oneshot_q <= w_oneshot_d;
            r_rep_cnt_q <= w_rep_cnt_d;
            r_cfg_err_q <= w_cfg_err_d;
            r_done_q    <= w_done_d;
        end
    end

    assign count   = r_count_q;
    assign state   = r_state_q;
    assign tc      = (r_state_q == ST_RUN) && w_last_count;
    assign busy    = (r_state_q == ST_RUN) || (r_state_q == ST_PAUSE);
    assign done    = r_done_q;
    assign cfg_err = r_cfg_err_q;

endmodule
`default_nettype wire

// File: doc/mod_n_counter_ctrl.md
Name: mod_n_counter_ctrl

Overview:
Programmable controller for the team's mod-N counting datapath. It accepts a modulus/repeat configuration through a valid/ready handshake, then runs a count of 0..N-1 with start, pause and abort control. It supports continuous and one-shot (repeat-limited) modes, and reports terminal count, completion and status. It sits between the system sequencer and any logic consuming the mod-N count.

Parameters:
WIDTH, 4, width of count and modulus (modulus range 2..2^WIDTH-1)
REP_W, 4, width of one-shot repeat counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on next clk edge)
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted (IDLE or DONE only)
cfg_mod  input  WIDTH  requested modulus N
cfg_reps  input  REP_W  number of full periods in one-shot mode (0 treated as 1)
cfg_oneshot  input  1  1 = one-shot mode, 0 = continuous
cfg_err  output  1  one-cycle pulse: offered config rejected (cfg_mod<2)
start  input  1  begin counting (honoured in IDLE/DONE only)
pause  input  1  level; freezes count while high in RUN
abort  input  1  return to IDLE from RUN/PAUSE
count  output  WIDTH  current count value
tc  output  1  terminal count: high while state==RUN and count==N-1
done  output  1  one-cycle pulse on first cycle in DONE
busy  output  1  state is RUN or PAUSE
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, count=0, mod_r={WIDTH{1'b1}}, reps_r=1, oneshot_r=0, rep_cnt=0, cfg_err=0, done=0. Derived outputs follow: cfg_ready=1, busy=0, tc=0. Reset overrides every other input, including mid-run.
- Config handshake: transfer occurs on a clk edge with cfg_valid&cfg_ready.
  - If cfg_mod>=2: latch mod_r, reps_r (0 stored as 1) and oneshot_r.
  - If cfg_mod<2: no registers change; cfg_err=1 for the following cycle only.
  - cfg_ready=0 in RUN/PAUSE. An offered config waits; it is never dropped silently.
- Priority in RUN/PAUSE: abort > pause > counting.
- IDLE/DONE + start -> RUN; count=0, rep_cnt=0, done cleared.
  - If a valid config transfers on the same edge, the new config governs this run.
  - start is ignored in RUN/PAUSE.
- RUN, per cycle:
  - If count==mod_r-1: count wraps to 0, rep_cnt increments.
  - Otherwise count increments by 1.
  - tc is a combinational decode of the registered state/count (zero added latency).
- One-shot end: in RUN with oneshot_r=1, count==mod_r-1 and rep_cnt==reps_r-1 -> next state DONE, count=0, done=1 for exactly one cycle. Total RUN cycles = mod_r*reps_r.
- Continuous mode: never enters DONE. rep_cnt wraps freely and is unused.
- RUN + pause=1 -> PAUSE on the next edge; count holds. tc=0 in PAUSE.
- PAUSE + pause=0 -> RUN; counting resumes from the held value.
- RUN/PAUSE + abort -> IDLE on the next edge; count=0, rep_cnt=0, no done pulse.
- DONE: count holds 0; accepts config; start restarts; stays in DONE otherwise.
- Arithmetic: count compare uses mod_r-1 in WIDTH bits. mod_r>=2 is guaranteed by the rejection rule, so no underflow. count never reaches or exceeds mod_r.
- No combinational path from inputs to outputs except cfg_ready and tc, which decode registered state only.

Test Plan:
1. Hold rst=0 for 2 cycles, then release -> count=0, state=0, cfg_ready=1, busy=0, tc=0, done=0, cfg_err=0.
2. Config mod=10, oneshot=0, then pulse start -> count runs 0..9 and wraps to 0 repeatedly. tc is high exactly when count=9, once per 10 cycles. done never pulses; busy=1 throughout.
3. Config mod=5, reps=3, oneshot=1, then start -> 15 RUN cycles with tc high 3 times. Then state=3, done high for 1 cycle, count=0, cfg_ready=1. A second start repeats the identical sequence.
4. mod=10 run:
   - Assert pause at count=3 for 4 cycles -> state=2, count holds 3, tc=0. Release -> count continues at 4.
   - Assert abort at count=6 -> next cycle state=0, count=0, no done.
   - Assert pause and abort on the same edge -> IDLE.
5. cfg_mod=1 with cfg_valid in IDLE -> cfg_err pulse, mod_r unchanged. cfg_valid with mod=7 during RUN -> cfg_ready=0, no transfer until IDLE/DONE. Config plus start on the same edge -> run uses mod=7.
6. Drive rst=0 mid-RUN at count=7 -> next edge restores all reset values (mod_r=15, state=0, count=0).
